// File: rtl/wb_daq_slave_pkg.sv
// Shared constants and types for the DAQ Wishbone slave: register indices,
// STATUS bit positions and the bus FSM state type.
package wb_daq_slave_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } state_t;

  localparam logic [2:0] REG_CONTROL = 3'd0;
  localparam logic [2:0] REG_STATUS  = 3'd1;
  localparam logic [2:0] REG_DATA    = 3'd2;
  localparam logic [2:0] REG_SCRATCH = 3'd3;

  localparam int unsigned STAT_EMPTY   = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_OVF     = 2;
  localparam int unsigned STAT_CNT_LSB = 16;

endpackage

// File: rtl/wb_daq_slave_if.sv
// Wishbone classic bus bundle between the interconnect (master) and the
// DAQ register slave.
interface wb_daq_slave_if #(
  parameter int unsigned dw = 32,
  parameter int unsigned aw = 32
);
  logic [aw-1:0] wb_adr_i;
  logic [dw-1:0] wb_dat_i;
  logic [3:0]    wb_sel_i;
  logic          wb_we_i;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic [2:0]    wb_cti_i;
  logic [1:0]    wb_bte_i;
  logic [dw-1:0] wb_dat_o;
  logic          wb_ack_o;
  logic          wb_err_o;
  logic          wb_rty_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
           wb_cti_i, wb_bte_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
           wb_cti_i, wb_bte_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/wb_daq_sync_fifo.sv
// Single-clock sample FIFO with first-word-fall-through head and a pulse
// flagging a push dropped because the FIFO was full.
module wb_daq_sync_fifo #(
  parameter int unsigned dw         = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FIFO_AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [dw-1:0]    push_data,
  input  logic             pop,
  output logic [dw-1:0]    pop_data,
  output logic [FIFO_AW:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow_set
);

  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(FIFO_DEPTH);

  logic [dw-1:0]      mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               do_push;
  logic               do_pop;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign count = count_q;

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_pop       = pop & ~empty;
  assign do_push      = push & (~full | do_pop);
  assign overflow_set = push & full & ~do_pop;

  assign pop_data = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (FIFO_AW + 1)'(1);
        2'b01:   count_q <= count_q - (FIFO_AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/wb_daq_slave.sv
// Wishbone classic slave exposing CONTROL/STATUS/DATA/SCRATCH for the DAQ path.
// Optional threshold/overflow interrupt output enabled by WB_DAQ_SLAVE_IRQ_EN.
module wb_daq_slave
  import wb_daq_slave_pkg::*;
#(
  parameter int unsigned dw         = 32,
  parameter int unsigned aw         = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FIFO_AW    = 4
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  wb_daq_slave_if.slave     wb,
  input  logic              sample_valid,
  input  logic [dw-1:0]     sample_data,
  output logic [dw-1:0]     control_reg
`ifdef WB_DAQ_SLAVE_IRQ_EN
  ,
  output logic              irq
`endif
);

  state_t           state_q;
  state_t           state_d;
  logic             take;
  logic [2:0]       reg_idx;

  logic             ack_d, err_d, rty_d;
  logic [dw-1:0]    dat_d;
  logic             ack_q, err_q, rty_q;
  logic [dw-1:0]    dat_q;

  logic             wr_control, wr_scratch, ovf_clr, fifo_pop;
  logic [dw-1:0]    control_q;
  logic [dw-1:0]    scratch_q;
  logic             overflow_q;
  logic [dw-1:0]    status_w;

  logic [dw-1:0]    fifo_head;
  logic [FIFO_AW:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_ovf_set;

  logic             unused_bits;

  function automatic logic [dw-1:0] merge_bytes(input logic [dw-1:0]   cur,
                                                input logic [dw-1:0]   wdat,
                                                input logic [dw/8-1:0] sel);
    logic [dw-1:0] m;
    m = cur;
    for (int unsigned k = 0; k < dw / 8; k++) begin
      if (sel[k]) begin
        m[8*k +: 8] = wdat[8*k +: 8];
      end
    end
    return m;
  endfunction

  wb_daq_sync_fifo #(
    .dw        (dw),
    .FIFO_DEPTH(FIFO_DEPTH),
    .FIFO_AW   (FIFO_AW)
  ) u_fifo (
    .clk         (wb_clk),
    .rst         (wb_rst),
    .push        (sample_valid),
    .push_data   (sample_data),
    .pop         (fifo_pop),
    .pop_data    (fifo_head),
    .count       (fifo_count),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .overflow_set(fifo_ovf_set)
  );

  assign reg_idx     = wb.wb_adr_i[4:2];
  assign unused_bits = ^{wb.wb_adr_i[aw-1:5], wb.wb_adr_i[1:0], wb.wb_cti_i, wb.wb_bte_i};

  always_comb begin
    status_w                                = '0;
    status_w[STAT_CNT_LSB +: FIFO_AW + 1]   = fifo_count;
    status_w[STAT_OVF]                      = overflow_q;
    status_w[STAT_FULL]                     = fifo_full;
    status_w[STAT_EMPTY]                    = fifo_empty;
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (wb.wb_cyc_i && wb.wb_stb_i) begin
          state_d = ST_RESP;
          take    = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Decode is evaluated only on the IDLE->RESP edge so every side effect fires once.
  always_comb begin
    ack_d      = 1'b0;
    err_d      = 1'b0;
    rty_d      = 1'b0;
    dat_d      = '0;
    wr_control = 1'b0;
    wr_scratch = 1'b0;
    ovf_clr    = 1'b0;
    fifo_pop   = 1'b0;
    if (take) begin
      unique case (reg_idx)
        REG_CONTROL: begin
          ack_d = 1'b1;
          if (wb.wb_we_i) wr_control = 1'b1;
          else            dat_d      = control_q;
        end
        REG_STATUS: begin
          ack_d = 1'b1;
          if (wb.wb_we_i) ovf_clr = wb.wb_dat_i[STAT_OVF] & wb.wb_sel_i[0];
          else            dat_d   = status_w;
        end
        REG_DATA: begin
          if (wb.wb_we_i) begin
            ack_d = 1'b1;
          end else if (fifo_empty) begin
            rty_d = 1'b1;
          end else begin
            ack_d    = 1'b1;
            fifo_pop = 1'b1;
            dat_d    = fifo_head;
          end
        end
        REG_SCRATCH: begin
          ack_d = 1'b1;
          if (wb.wb_we_i) wr_scratch = 1'b1;
          else            dat_d      = scratch_q;
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      control_q  <= '0;
      scratch_q  <= '0;
      overflow_q <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rty_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      if (wr_control) control_q <= merge_bytes(control_q, wb.wb_dat_i, wb.wb_sel_i);
      if (wr_scratch) scratch_q <= merge_bytes(scratch_q, wb.wb_dat_i, wb.wb_sel_i);
      if (fifo_ovf_set)  overflow_q <= 1'b1;
      else if (ovf_clr)  overflow_q <= 1'b0;
      ack_q <= ack_d;
      err_q <= err_d;
      rty_q <= rty_d;
      dat_q <= dat_d;
    end
  end

  // Gated by reset so a transfer caught by reset never shows its termination.
  assign wb.wb_ack_o = ack_q & ~wb_rst;
  assign wb.wb_err_o = err_q & ~wb_rst;
  assign wb.wb_rty_o = rty_q & ~wb_rst;
  assign wb.wb_dat_o = wb_rst ? '0 : dat_q;
  assign control_reg = control_q;

`ifdef WB_DAQ_SLAVE_IRQ_EN
  logic [7:0] irq_thr;
  logic       irq_q;

  assign irq_thr = control_q[31:24];

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= ((irq_thr != 8'd0) && (32'(fifo_count) >= 32'(irq_thr))) | overflow_q;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_wb_daq_slave.sv
// Scoreboard bench for wb_daq_slave: a behavioural register/FIFO model predicts
// each bus response at drive time; responses are popped and compared on termination.
module tb_wb_daq_slave;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst;
  logic        sample_valid;
  logic [31:0] sample_data;
  logic [31:0] control_reg;
`ifdef WB_DAQ_SLAVE_IRQ_EN
  logic        irq;
`endif

  wb_daq_slave_if #(.dw(32), .aw(32)) bus_if ();

  wb_daq_slave #(
    .dw        (32),
    .aw        (32),
    .FIFO_DEPTH(DEPTH),
    .FIFO_AW   (4)
  ) dut (
    .wb_clk      (clk),
    .wb_rst      (rst),
    .wb          (bus_if),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .control_reg (control_reg)
`ifdef WB_DAQ_SLAVE_IRQ_EN
    ,
    .irq         (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp;
  int unsigned n_bad;

  logic [31:0] m_ctrl;
  logic [31:0] m_scr;
  logic        m_ovf;
  logic [31:0] m_fifo[$];

  logic [2:0]  sb_term[$];
  logic [31:0] sb_data[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] d,
                                        input logic [3:0] sel);
    logic [31:0] m;
    m = cur;
    if (sel[0]) m[7:0]   = d[7:0];
    if (sel[1]) m[15:8]  = d[15:8];
    if (sel[2]) m[23:16] = d[23:16];
    if (sel[3]) m[31:24] = d[31:24];
    return m;
  endfunction

  function automatic logic [31:0] status_model();
    logic [31:0] s;
    s        = '0;
    s[31:16] = 16'(m_fifo.size());
    s[2]     = m_ovf;
    s[1]     = (m_fifo.size() == DEPTH);
    s[0]     = (m_fifo.size() == 0);
    return s;
  endfunction

  task automatic model_push(input logic [31:0] d);
    if (m_fifo.size() < DEPTH) m_fifo.push_back(d);
    else                       m_ovf = 1'b1;
  endtask

  task automatic model_reset();
    m_ctrl = '0;
    m_scr  = '0;
    m_ovf  = 1'b0;
    m_fifo.delete();
  endtask

  // One classic transfer; optionally a sample push coincident with the slave's decode edge.
  task automatic bus(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input logic we,
                     input logic cpush, input logic [31:0] cdata);
    logic [2:0]  idx;
    logic [2:0]  eterm;
    logic [31:0] edata;
    logic [2:0]  term;
    int unsigned lat;
    idx   = adr[4:2];
    eterm = 3'b100;
    edata = '0;
    case (idx)
      3'd0: if (we) m_ctrl = merge(m_ctrl, dat, sel); else edata = m_ctrl;
      3'd1: begin
        if (we) begin
          if (dat[2] && sel[0]) m_ovf = 1'b0;
        end else begin
          edata = status_model();
        end
      end
      3'd2: begin
        if (!we) begin
          if (m_fifo.size() == 0) eterm = 3'b001;
          else                    edata = m_fifo.pop_front();
        end
      end
      3'd3: if (we) m_scr = merge(m_scr, dat, sel); else edata = m_scr;
      default: eterm = 3'b010;
    endcase
    if (cpush) model_push(cdata);
    sb_term.push_back(eterm);
    sb_data.push_back(edata);

    @(posedge clk); #1;
    bus_if.wb_adr_i = adr;
    bus_if.wb_dat_i = dat;
    bus_if.wb_sel_i = sel;
    bus_if.wb_we_i  = we;
    bus_if.wb_cyc_i = 1'b1;
    bus_if.wb_stb_i = 1'b1;
    if (cpush) begin
      sample_valid = 1'b1;
      sample_data  = cdata;
    end
    lat  = 0;
    term = '0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (cpush && lat >= 2) sample_valid = 1'b0;
      term = {bus_if.wb_ack_o, bus_if.wb_err_o, bus_if.wb_rty_o};
      if (term != 3'b000) break;
    end
    sample_valid = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'd2);
    check({tag, " term"}, {29'd0, term}, {29'd0, sb_term.pop_front()});
    check({tag, " data"}, bus_if.wb_dat_o, sb_data.pop_front());
    @(posedge clk); #1;
    bus_if.wb_cyc_i = 1'b0;
    bus_if.wb_stb_i = 1'b0;
    bus_if.wb_we_i  = 1'b0;
    @(negedge clk);
    check({tag, " pulse"}, {29'd0, bus_if.wb_ack_o, bus_if.wb_err_o, bus_if.wb_rty_o}, 32'd0);
    check({tag, " control_reg"}, control_reg, m_ctrl);
  endtask

  task automatic rd(input string tag, input logic [31:0] adr);
    bus(tag, adr, 32'd0, 4'hF, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic wr(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                    input logic [3:0] sel);
    bus(tag, adr, dat, sel, 1'b1, 1'b0, 32'd0);
  endtask

  task automatic push_samples(input int n, input logic [31:0] base, input logic [31:0] step);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      sample_valid = 1'b1;
      sample_data  = base + step * 32'(i);
      model_push(sample_data);
    end
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    sample_valid = 1'b0;
    sample_data  = '0;
    bus_if.wb_adr_i = '0;
    bus_if.wb_dat_i = '0;
    bus_if.wb_sel_i = '0;
    bus_if.wb_we_i  = 1'b0;
    bus_if.wb_cyc_i = 1'b0;
    bus_if.wb_stb_i = 1'b0;
    bus_if.wb_cti_i = '0;
    bus_if.wb_bte_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset term", {29'd0, bus_if.wb_ack_o, bus_if.wb_err_o, bus_if.wb_rty_o}, 32'd0);
    check("reset dat", bus_if.wb_dat_o, 32'd0);
    check("reset control_reg", control_reg, 32'd0);

    rd("status empty", 32'h04);
    rd("control init", 32'h00);
    rd("scratch init", 32'h0C);

    wr("scratch full", 32'h0C, 32'h11223344, 4'hF);
    wr("scratch lanes", 32'h0C, 32'hAABBCCDD, 4'b0101);
    rd("scratch merged", 32'h0C);
    check("merge constant", m_scr, 32'h11BB33DD);
    wr("control write", 32'h00, 32'hDEADBEEF, 4'hF);
    rd("control read", 32'h00);

    push_samples(3, 32'h10, 32'h10);
    rd("status three", 32'h04);
    rd("data pop0", 32'h08);
    rd("data pop1", 32'h08);
    rd("data pop2", 32'h08);
    rd("data empty retry", 32'h08);
    rd("status drained", 32'h04);

    push_samples(17, 32'h100, 32'h1);
    rd("status overflow", 32'h04);
    wr("status clear", 32'h04, 32'h4, 4'h1);
    rd("status cleared", 32'h04);
    bus("data pop with push", 32'h08, 32'd0, 4'hF, 1'b0, 1'b1, 32'h5A5A0001);
    rd("status full no ovf", 32'h04);

    wr("data write ignored", 32'h08, 32'hFFFFFFFF, 4'hF);
    rd("status after data write", 32'h04);

    rd("unmapped read", 32'h14);
    wr("unmapped write", 32'h14, 32'h12345678, 4'hF);
    wr("unmapped write hi", 32'h1C, 32'h87654321, 4'hF);
    rd("control after err", 32'h00);
    rd("scratch after err", 32'h0C);

    for (int i = 0; i < 6; i++) begin
      wr("rand scratch wr", 32'h0C, $urandom, 4'($urandom_range(0, 15)));
      rd("rand scratch rd", 32'h0C);
    end

    // reset while the slave is in RESP for a SCRATCH read
    @(posedge clk); #1;
    bus_if.wb_adr_i = 32'h0C;
    bus_if.wb_we_i  = 1'b0;
    bus_if.wb_sel_i = 4'hF;
    bus_if.wb_cyc_i = 1'b1;
    bus_if.wb_stb_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst in resp term", {29'd0, bus_if.wb_ack_o, bus_if.wb_err_o, bus_if.wb_rty_o}, 32'd0);
    check("rst in resp dat", bus_if.wb_dat_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus_if.wb_cyc_i = 1'b0;
    bus_if.wb_stb_i = 1'b0;
    model_reset();
    @(negedge clk);
    check("post rst term", {29'd0, bus_if.wb_ack_o, bus_if.wb_err_o, bus_if.wb_rty_o}, 32'd0);
    check("post rst dat", bus_if.wb_dat_o, 32'd0);
    check("post rst control_reg", control_reg, 32'd0);
    rd("post rst status", 32'h04);
    rd("post rst scratch", 32'h0C);

`ifdef WB_DAQ_SLAVE_IRQ_EN
    wr("irq threshold", 32'h00, 32'h04000000, 4'b1000);
    push_samples(3, 32'h200, 32'h1);
    @(posedge clk);
    @(negedge clk);
    check("irq below thr", {31'd0, irq}, 32'd0);
    push_samples(1, 32'h203, 32'h1);
    @(posedge clk);
    @(negedge clk);
    check("irq at thr", {31'd0, irq}, 32'd1);
    rd("irq pop", 32'h08);
    check("irq after pop", {31'd0, irq}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
